// File: rtl/cache_fill_controller.sv
// cache_fill_controller: read-request controller sitting in front of a
// direct-mapped cache. Accepts one word read at a time, looks it up in the
// cache, and on a miss fetches the 4-word line from RAM (word 0 first),
// writes the assembled line into the cache and then answers the request.
// Keeps saturating hit and miss counters.
//
// Ports:
//   globalclock              sole clock, rising edge
//   reset                    synchronous, active-low
//   req_valid/req_addr       CPU read request (word address)
//   req_ready                high only while idle
//   resp_valid/resp_data     response word, held until resp_ready
//   resp_ready               CPU accepts the response
//   cache_addr               address presented to the cache (lookup and write)
//   cache_wrEn/cache_line    one-cycle line write into the cache
//   cache_hit/cache_rdata    combinational cache answer for cache_addr
//   mem_rd_req/mem_addr      one-cycle RAM word read request
//   mem_rd_valid/mem_rd_data RAM read return
//   hit_count/miss_count     saturating event counters
module cache_fill_controller #(
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned WORD_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                  globalclock,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic [ADDR_W-1:0]     req_addr,
  output logic                  req_ready,
  output logic                  resp_valid,
  output logic [WORD_W-1:0]     resp_data,
  input  logic                  resp_ready,
  output logic [ADDR_W-1:0]     cache_addr,
  output logic                  cache_wrEn,
  output logic [4*WORD_W-1:0]   cache_line,
  input  logic                  cache_hit,
  input  logic [WORD_W-1:0]     cache_rdata,
  output logic                  mem_rd_req,
  output logic [ADDR_W-1:0]     mem_addr,
  input  logic                  mem_rd_valid,
  input  logic [WORD_W-1:0]     mem_rd_data,
  output logic [CNT_W-1:0]      hit_count,
  output logic [CNT_W-1:0]      miss_count
);

  localparam int unsigned LINE_W = 4 * WORD_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_FILL_REQ,
    S_FILL_WAIT,
    S_WRITE,
    S_RESPOND
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [1:0]          word_q, word_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic [WORD_W-1:0]   resp_data_d;
  logic [CNT_W-1:0]    hit_d, miss_d;

  // Next-state and datapath updates
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    word_d      = word_q;
    line_d      = line_q;
    resp_data_d = resp_data;
    hit_d       = hit_count;
    miss_d      = miss_count;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          addr_d  = req_addr;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (cache_hit) begin
          resp_data_d = cache_rdata;
          if (hit_count != CNT_MAX) hit_d = hit_count + CNT_W'(1);
          state_d = S_RESPOND;
        end else begin
          if (miss_count != CNT_MAX) miss_d = miss_count + CNT_W'(1);
          word_d  = '0;
          line_d  = '0;
          state_d = S_FILL_REQ;
        end
      end
      S_FILL_REQ: state_d = S_FILL_WAIT;
      S_FILL_WAIT: begin
        if (mem_rd_valid) begin
          // word k lands in the top-down slot [127-32k -: 32]
          line_d[WORD_W*(32'd3 - 32'(word_q)) +: WORD_W] = mem_rd_data;
          if (word_q == 2'd3) begin
            state_d = S_WRITE;
          end else begin
            word_d  = word_q + 2'd1;
            state_d = S_FILL_REQ;
          end
        end
      end
      S_WRITE: begin
        resp_data_d = line_q[WORD_W*(32'd3 - 32'(addr_q[1:0])) +: WORD_W];
        state_d     = S_RESPOND;
      end
      S_RESPOND: begin
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, datapath and registered outputs; outputs follow the state being entered
  always_ff @(posedge globalclock) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      word_q     <= '0;
      line_q     <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      cache_addr <= '0;
      cache_wrEn <= 1'b0;
      cache_line <= '0;
      mem_rd_req <= 1'b0;
      mem_addr   <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      word_q     <= word_d;
      line_q     <= line_d;
      resp_data  <= resp_data_d;
      hit_count  <= hit_d;
      miss_count <= miss_d;
      req_ready  <= (state_d == S_IDLE);
      resp_valid <= (state_d == S_RESPOND);
      cache_wrEn <= (state_d == S_WRITE);
      cache_line <= (state_d == S_WRITE) ? line_d : '0;
      cache_addr <= (state_d == S_LOOKUP || state_d == S_WRITE) ? addr_d : '0;
      mem_rd_req <= (state_d == S_FILL_REQ);
      mem_addr   <= (state_d == S_FILL_REQ) ? {addr_d[ADDR_W-1:2], word_d} : '0;
    end
  end

endmodule

// File: tb/tb_cache_fill_controller.sv
// Testbench for cache_fill_controller: RAM and cache environment models,
// a tag-array reference model feeding scoreboard queues, and a negedge
// monitor that checks every response, cache write and RAM request.
module tb_cache_fill_controller;

  localparam int unsigned SAT_W = 6;

  logic globalclock = 1'b0;
  always #5 globalclock = ~globalclock;

  logic          reset = 1'b0;
  logic          req_valid = 1'b0;
  logic [14:0]   req_addr = '0;
  logic          req_ready;
  logic          resp_valid;
  logic [31:0]   resp_data;
  logic          resp_ready = 1'b1;
  logic [14:0]   cache_addr;
  logic          cache_wrEn;
  logic [127:0]  cache_line;
  logic          cache_hit;
  logic [31:0]   cache_rdata;
  logic          mem_rd_req;
  logic [14:0]   mem_addr;
  logic          mem_rd_valid = 1'b0;
  logic [31:0]   mem_rd_data = '0;
  logic [15:0]   hit_count;
  logic [15:0]   miss_count;

  cache_fill_controller dut (
    .globalclock (globalclock),  .reset       (reset),
    .req_valid   (req_valid),    .req_addr    (req_addr),
    .req_ready   (req_ready),    .resp_valid  (resp_valid),
    .resp_data   (resp_data),    .resp_ready  (resp_ready),
    .cache_addr  (cache_addr),   .cache_wrEn  (cache_wrEn),
    .cache_line  (cache_line),   .cache_hit   (cache_hit),
    .cache_rdata (cache_rdata),  .mem_rd_req  (mem_rd_req),
    .mem_addr    (mem_addr),     .mem_rd_valid(mem_rd_valid),
    .mem_rd_data (mem_rd_data),  .hit_count   (hit_count),
    .miss_count  (miss_count)
  );

  // Narrow-counter instance with the cache forced to hit, for saturation
  logic              s_req_valid = 1'b0;
  logic [14:0]       s_req_addr = 15'h0ABC;
  logic              s_req_ready, s_resp_valid, s_cache_wrEn, s_mem_rd_req;
  logic [31:0]       s_resp_data;
  logic [14:0]       s_cache_addr, s_mem_addr;
  logic [127:0]      s_cache_line;
  logic [SAT_W-1:0]  s_hit_count, s_miss_count;
  logic [31:0]       sat_word = 32'h5A70_C0DE;

  cache_fill_controller #(.CNT_W(SAT_W)) dut_sat (
    .globalclock (globalclock),  .reset       (reset),
    .req_valid   (s_req_valid),  .req_addr    (s_req_addr),
    .req_ready   (s_req_ready),  .resp_valid  (s_resp_valid),
    .resp_data   (s_resp_data),  .resp_ready  (1'b1),
    .cache_addr  (s_cache_addr), .cache_wrEn  (s_cache_wrEn),
    .cache_line  (s_cache_line), .cache_hit   (1'b1),
    .cache_rdata (sat_word),     .mem_rd_req  (s_mem_rd_req),
    .mem_addr    (s_mem_addr),   .mem_rd_valid(1'b0),
    .mem_rd_data (32'h0),        .hit_count   (s_hit_count),
    .miss_count  (s_miss_count)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge globalclock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge globalclock);
    #1;
  endtask

  // RAM: each request answered exactly mem_lat cycles later
  logic [31:0] ram [32768];
  int          mem_lat = 2;
  typedef struct { logic [14:0] a; int due; } mreq_t;
  mreq_t mq[$];

  always @(negedge globalclock) begin
    mem_rd_valid = 1'b0;
    mem_rd_data  = $urandom();
    if (reset && mem_rd_req) mq.push_back('{a: mem_addr, due: cyc + mem_lat});
    if (mq.size() > 0 && mq[0].due == cyc) begin
      mem_rd_valid = 1'b1;
      mem_rd_data  = ram[mq[0].a];
      void'(mq.pop_front());
    end
  end

  // Cache storage, written only by the DUT's line writes
  logic [127:0] cdata [1024];
  logic [2:0]   ctag  [1024];
  logic         cvld  [1024];

  always_comb begin
    cache_hit   = cvld[cache_addr[11:2]] && (ctag[cache_addr[11:2]] == cache_addr[14:12]);
    cache_rdata = cdata[cache_addr[11:2]][127 - 32*int'(cache_addr[1:0]) -: 32];
  end

  // Reference model: tag array of what the cache should hold
  logic        rvld [1024];
  logic [2:0]  rtag [1024];
  logic [15:0] m_hits = '0, m_misses = '0;

  typedef struct { logic [31:0] data; logic [15:0] hits; logic [15:0] misses; int acc; int lat; } rsp_t;
  typedef struct { logic [14:0] a; logic [127:0] line; } wr_t;
  rsp_t        exp_rsp[$];
  wr_t         exp_wr[$];
  logic [14:0] exp_mem[$];

  task automatic model_push(input logic [14:0] a, input int acc);
    rsp_t r;
    wr_t  w;
    logic [9:0]  idx;
    logic [14:0] base;
    idx  = a[11:2];
    base = {a[14:2], 2'b00};
    if (rvld[idx] && rtag[idx] == a[14:12]) begin
      if (m_hits != 16'hFFFF) m_hits = m_hits + 16'd1;
      r.lat = 2;
    end else begin
      if (m_misses != 16'hFFFF) m_misses = m_misses + 16'd1;
      rvld[idx] = 1'b1;
      rtag[idx] = a[14:12];
      for (int k = 0; k < 4; k++) exp_mem.push_back(base + 15'(k));
      w.a    = a;
      w.line = {ram[base], ram[base + 15'd1], ram[base + 15'd2], ram[base + 15'd3]};
      exp_wr.push_back(w);
      r.lat = 2 + 4 * (mem_lat + 1) + 1;
    end
    r.data   = ram[a];
    r.hits   = m_hits;
    r.misses = m_misses;
    r.acc    = acc;
    exp_rsp.push_back(r);
  endtask

  // Monitor
  logic        abort_mode = 1'b0;
  logic        prev_rv = 1'b0;
  logic [31:0] held_data = '0;
  int          n_memreq = 0, n_wr = 0, n_s = 0;

  always @(negedge globalclock) begin
    if (!reset) begin
      prev_rv = 1'b0;
    end else begin
      if (mem_rd_req) begin
        n_memreq++;
        if (exp_mem.size() > 0) chk("mem_addr", 128'(mem_addr), 128'(exp_mem.pop_front()));
        else if (!abort_mode) chk("unexpected mem_rd_req", 128'(mem_rd_req), 128'(0));
      end
      if (cache_wrEn) begin
        n_wr++;
        if (exp_wr.size() > 0) begin
          wr_t w;
          w = exp_wr.pop_front();
          chk("cache_addr at write", 128'(cache_addr), 128'(w.a));
          chk("cache_line", cache_line, w.line);
        end else begin
          chk("unexpected cache_wrEn", 128'(cache_wrEn), 128'(0));
        end
        cdata[cache_addr[11:2]] = cache_line;
        ctag[cache_addr[11:2]]  = cache_addr[14:12];
        cvld[cache_addr[11:2]]  = 1'b1;
      end
      if (resp_valid && !prev_rv) begin
        if (exp_rsp.size() > 0) begin
          rsp_t r;
          r = exp_rsp.pop_front();
          chk("resp_data", 128'(resp_data), 128'(r.data));
          chk("hit_count", 128'(hit_count), 128'(r.hits));
          chk("miss_count", 128'(miss_count), 128'(r.misses));
          chk("latency", 128'(cyc - r.acc), 128'(r.lat));
        end else begin
          chk("unexpected resp_valid", 128'(resp_valid), 128'(0));
        end
        held_data = resp_data;
      end else if (resp_valid) begin
        chk("resp_data stable", 128'(resp_data), 128'(held_data));
      end
      if (resp_valid) chk("req_ready while responding", 128'(req_ready), 128'(0));
      prev_rv = resp_valid;

      if (s_resp_valid) begin
        n_s++;
        chk("sat hit_count", 128'(s_hit_count), 128'((n_s < 63) ? n_s : 63));
        chk("sat miss_count", 128'(s_miss_count), 128'(0));
        chk("sat resp_data", 128'(s_resp_data), 128'(sat_word));
        chk("sat idle strobes", {s_cache_line, s_cache_addr, s_mem_addr, s_mem_rd_req, s_cache_wrEn, s_req_ready}, 128'(0));
      end
    end
  end

  task automatic wait_idle();
    int t = 0;
    while (!req_ready && t < 100) begin tick(); t++; end
    if (!req_ready) chk("timeout waiting for req_ready", 128'(req_ready), 128'(1));
  endtask

  // One request; hold = cycles resp_ready stays low once the response is up
  task automatic do_req(input logic [14:0] a, input int hold);
    int t;
    wait_idle();
    req_valid  = 1'b1;
    req_addr   = a;
    resp_ready = (hold == 0);
    model_push(a, cyc);
    tick();
    req_valid = 1'b0;
    req_addr  = 15'($urandom());
    t = 0;
    while (!resp_valid && t < 200) begin tick(); t++; end
    if (!resp_valid) begin
      chk("timeout waiting for resp_valid", 128'(resp_valid), 128'(1));
      resp_ready = 1'b1;
      return;
    end
    repeat (hold) tick();
    resp_ready = 1'b1;
    tick();
  endtask

  logic [9:0] idx_pool [4] = '{10'h08D, 10'h000, 10'h3FF, 10'h155};

  initial begin
    int t, m0, w0;
    for (int i = 0; i < 32768; i++) ram[i] = $urandom();
    for (int i = 0; i < 1024; i++) begin
      cvld[i] = 1'b0; ctag[i] = '0; cdata[i] = '0; rvld[i] = 1'b0; rtag[i] = '0;
    end

    // Reset held with a request pending
    reset = 1'b0; req_valid = 1'b1; req_addr = 15'h1235;
    tick(); tick();
    chk("reset req_ready", 128'(req_ready), 128'(1));
    chk("reset resp/cache/mem outputs",
        {resp_valid, resp_data, cache_wrEn, cache_addr, mem_rd_req, mem_addr}, 128'(0));
    chk("reset cache_line", cache_line, 128'(0));
    chk("reset counters", 128'({hit_count, miss_count}), 128'(0));
    req_valid = 1'b0; reset = 1'b1;
    tick(); tick();
    chk("no request accepted in reset", 128'({req_ready, cache_addr, mem_rd_req}), 128'({1'b1, 15'h0, 1'b0}));

    // Cold miss, conflict-free hit, conflict miss, backpressured hit
    mem_lat = 2;
    do_req(15'h1235, 0);
    m0 = n_memreq;
    do_req(15'h1237, 0);
    chk("hit issues no RAM reads", 128'(n_memreq - m0), 128'(0));
    do_req(15'h2234, 0);
    do_req(15'h2236, 5);

    // Randomized traffic
    for (int i = 0; i < 60; i++) begin
      mem_lat = $urandom_range(1, 4);
      do_req({3'($urandom_range(0, 7)), idx_pool[$urandom_range(0, 3)], 2'($urandom_range(0, 3))},
             $urandom_range(0, 3));
    end

    // Reset during FILL_WAIT abandons the fill; the late RAM word is ignored
    tick();
    wait_idle();
    mem_lat = 4;
    abort_mode = 1'b1;
    req_valid = 1'b1; req_addr = 15'h6C01;
    tick();
    req_valid = 1'b0;
    t = 0;
    while (!mem_rd_req && t < 20) begin tick(); t++; end
    chk("abort fill starts", 128'(mem_rd_req), 128'(1));
    tick();
    w0 = n_wr;
    reset = 1'b0;
    tick();
    chk("reset mid-fill outputs", 128'({req_ready, resp_valid, mem_rd_req, cache_wrEn}), 128'(4'b1000));
    tick();
    reset = 1'b1;
    repeat (12) tick();
    chk("no write after abort", 128'(n_wr - w0), 128'(0));
    chk("idle after abort", 128'({req_ready, resp_valid}), 128'(2'b10));
    chk("counters cleared", 128'({hit_count, miss_count}), 128'(0));
    m_hits = '0; m_misses = '0;
    exp_mem.delete();
    abort_mode = 1'b0;

    // Recovery traffic, including the abandoned address
    mem_lat = 1;
    do_req(15'h6C01, 0);
    do_req(15'h6C03, 1);
    do_req(15'h1234, 0);

    // Saturation of the narrow counter with forced hits
    s_req_valid = 1'b1;
    t = 0;
    while (n_s < 70 && t < 400) begin tick(); t++; end
    s_req_valid = 1'b0;
    chk("sat handshakes reached", 128'(n_s >= 70), 128'(1));

    repeat (5) tick();
    chk("scoreboard drained", 128'({32'(exp_rsp.size()), 32'(exp_wr.size()), 32'(exp_mem.size())}), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (got cycle %0d, required < 50000)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
